// File: rtl/branch_resolve_unit.sv
// EX-side branch resolution: carries fetch-time predictions down a tag pipe,
// compares them with resolved outcomes, drives BTB update, redirect and stats.
module branch_resolve_unit #(
  parameter int PIPE_DEPTH = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             en,
  input  logic             fetch_valid,
  input  logic [63:0]      fetch_pc,
  input  logic [63:0]      fetch_pred_pc,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [63:0]      ex_target,
  output logic             btb_en,
  output logic [63:0]      btb_prev_pc,
  output logic [63:0]      btb_branch_pc,
  output logic             btb_was_taken,
  output logic             redirect_valid,
  output logic [63:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  logic [PIPE_DEPTH-1:0] tag_v;
  logic [63:0]           tag_pc   [PIPE_DEPTH];
  logic [63:0]           tag_pred [PIPE_DEPTH];

  logic        r_valid;
  logic [63:0] r_pc;
  logic [63:0] r_pred;
  logic        res;
  logic        taken;
  logic        mis;
  logic [63:0] next_pc;

  assign r_valid = tag_v[PIPE_DEPTH-1];
  assign r_pc    = tag_pc[PIPE_DEPTH-1];
  assign r_pred  = tag_pred[PIPE_DEPTH-1];

  always_comb begin
    res     = en & ex_valid & r_valid;
    taken   = ex_is_branch & ex_taken;
    next_pc = taken ? ex_target : r_pc + 64'd4;
    mis     = res & (taken ? (r_pred != ex_target)
                           : (r_pred != 64'd0));
  end

  // A mispredict squashes every in-flight tag, including this cycle's fetch.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      tag_v <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        tag_pc[i]   <= '0;
        tag_pred[i] <= '0;
      end
    end else if (en) begin
      tag_v[0]    <= fetch_valid & ~mis;
      tag_pc[0]   <= fetch_pc;
      tag_pred[0] <= fetch_pred_pc;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        tag_v[i]    <= tag_v[i-1] & ~mis;
        tag_pc[i]   <= tag_pc[i-1];
        tag_pred[i] <= tag_pred[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      btb_en           <= 1'b0;
      btb_prev_pc      <= '0;
      btb_branch_pc    <= '0;
      btb_was_taken    <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= '0;
      flush            <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      btb_en         <= en;
      btb_was_taken  <= res & taken;
      redirect_valid <= mis;
      flush          <= mis;
      if (res && taken) begin
        btb_prev_pc   <= r_pc;
        btb_branch_pc <= ex_target;
      end
      if (mis)
        redirect_pc <= next_pc;
      if (res && ex_is_branch && branch_count != '1)
        branch_count <= branch_count + CNT_W'(1);
      if (mis && mispredict_count != '1)
        mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule
